sfft_frame_buffer: RTL and testbench

//  Parametrised sliding-window frame buffer that sits in front of the SFFT core.

---
 rtl/sfft_frame_buffer_if.sv | 25 ++
 rtl/sfft_frame_buffer.sv | 212 +++++++++++++++++++++
 tb/tb_sfft_frame_buffer.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/sfft_frame_buffer_if.sv
// Sample-in / frame-out stream bundle for sfft_frame_buffer.
// The design drives the frame side through the slave modport; the source and sink use master.
interface sfft_frame_buffer_if #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned LOG2_NFFT    = 5
);
    logic signed [SAMPLE_WIDTH-1:0] SampleAmplitudeIn;
    logic                           advanceSignal;
    logic                           frame_accept;
    logic                           frame_valid;
    logic signed [SAMPLE_WIDTH-1:0] frame_data;
    logic [LOG2_NFFT-1:0]           frame_index;
    logic                           frame_last;
    logic                           overrun;

    modport master (
        output SampleAmplitudeIn, advanceSignal, frame_accept,
        input  frame_valid, frame_data, frame_index, frame_last, overrun
    );

    modport slave (
        input  SampleAmplitudeIn, advanceSignal, frame_accept,
        output frame_valid, frame_data, frame_index, frame_last, overrun
    );
endinterface

// File: rtl/sfft_frame_buffer.sv
// Sliding-window frame buffer feeding the SFFT core: decimated sample capture into a
// 2*NFFT ring, NFFT-sample frames every HOP samples. Macro SFFT_BARTLETT_WINDOW_EN adds a triangular window.
module sfft_frame_buffer #(
    parameter int unsigned SAMPLE_WIDTH = 24,
    parameter int unsigned NFFT         = 32,
    parameter int unsigned LOG2_NFFT    = 5,
    parameter int unsigned HOP          = 8,
    parameter int unsigned DECIM        = 1,
    parameter int unsigned BIT_REVERSE  = 0
) (
    input  logic             clk,
    input  logic             reset,
    sfft_frame_buffer_if.slave bus
);
    localparam int unsigned PTR_W = LOG2_NFFT + 1;
    localparam int unsigned CNT_W = LOG2_NFFT + 1;
    localparam int unsigned DEC_W = 4;
    localparam int unsigned DEPTH = 2 * NFFT;

    typedef enum logic {IDLE, EMIT} state_e;

    state_e                         state_q;
    logic [DEC_W-1:0]               decim_cnt_q;
    logic [PTR_W-1:0]               wr_ptr_q, start_ptr_q, pend_ptr_q;
    logic [CNT_W-1:0]               fill_q, hop_cnt_q, emit_acc_q;
    logic                           pend_q, overrun_q;
    logic [LOG2_NFFT-1:0]           issue_k_q;
    logic                           issue_done_q;
    logic signed [SAMPLE_WIDTH-1:0] ram_q [DEPTH];
    logic signed [SAMPLE_WIDTH-1:0] rd_q;
    logic                           s1_vld_q, s1_last_q;
    logic [LOG2_NFFT-1:0]           s1_idx_q;
    logic                           out_vld_q, out_last_q;
    logic signed [SAMPLE_WIDTH-1:0] out_data_q;
    logic [LOG2_NFFT-1:0]           out_idx_q;

    logic                 accept_c, due_c, pipe_en_c, done_c, issue_c, frame_start_c;
    logic [PTR_W-1:0]     wr_ptr_d, due_ptr_c, rd_addr_c, frame_ptr_c;
    logic [CNT_W-1:0]     fill_d, hop_d;
    logic [LOG2_NFFT-1:0] t_c;

    function automatic logic [LOG2_NFFT-1:0] bitrev(input logic [LOG2_NFFT-1:0] v);
        logic [LOG2_NFFT-1:0] r;
        for (int i = 0; i < int'(LOG2_NFFT); i++) r[i] = v[LOG2_NFFT-1-i];
        return r;
    endfunction

    // Capture bookkeeping, frame-due detection and read-pipeline control.
    always_comb begin
        accept_c  = bus.advanceSignal && (decim_cnt_q == '0);
        wr_ptr_d  = wr_ptr_q + PTR_W'(1);
        fill_d    = (fill_q == CNT_W'(NFFT)) ? fill_q : fill_q + CNT_W'(1);
        hop_d     = (hop_cnt_q == CNT_W'(HOP)) ? hop_cnt_q : hop_cnt_q + CNT_W'(1);
        due_c     = accept_c && (fill_d == CNT_W'(NFFT)) && (hop_d == CNT_W'(HOP));
        due_ptr_c = wr_ptr_d - PTR_W'(NFFT);
        pipe_en_c = !out_vld_q || bus.frame_accept;
        done_c    = out_vld_q && bus.frame_accept && out_last_q;
        issue_c   = (state_q == EMIT) && !issue_done_q && pipe_en_c;
        t_c       = (BIT_REVERSE != 0) ? bitrev(issue_k_q) : issue_k_q;
        rd_addr_c = start_ptr_q + PTR_W'(t_c);

        frame_start_c = 1'b0;
        frame_ptr_c   = due_ptr_c;
        if (state_q == IDLE) begin
            frame_start_c = due_c;
        end else if (done_c) begin
            if (pend_q) begin
                frame_start_c = 1'b1;
                frame_ptr_c   = pend_ptr_q;
            end else begin
                frame_start_c = due_c;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            decim_cnt_q  <= '0;
            wr_ptr_q     <= '0;
            start_ptr_q  <= '0;
            pend_ptr_q   <= '0;
            fill_q       <= '0;
            hop_cnt_q    <= '0;
            emit_acc_q   <= '0;
            pend_q       <= 1'b0;
            overrun_q    <= 1'b0;
            issue_k_q    <= '0;
            issue_done_q <= 1'b1;
        end else begin
            if (bus.advanceSignal)
                decim_cnt_q <= (decim_cnt_q == DEC_W'(DECIM - 1)) ? '0 : decim_cnt_q + DEC_W'(1);
            if (accept_c) begin
                wr_ptr_q  <= wr_ptr_d;
                fill_q    <= fill_d;
                hop_cnt_q <= due_c ? '0 : hop_d;
            end
            if (frame_start_c) begin
                start_ptr_q  <= frame_ptr_c;
                issue_k_q    <= '0;
                issue_done_q <= 1'b0;
                emit_acc_q   <= '0;
            end else begin
                if (issue_c) begin
                    issue_k_q <= issue_k_q + LOG2_NFFT'(1);
                    if (issue_k_q == LOG2_NFFT'(NFFT - 1)) issue_done_q <= 1'b1;
                end
                // NFFT new samples during one frame can overwrite its unread tail.
                if ((state_q == EMIT) && accept_c && (emit_acc_q != CNT_W'(NFFT))) begin
                    emit_acc_q <= emit_acc_q + CNT_W'(1);
                    if (emit_acc_q == CNT_W'(NFFT - 1)) overrun_q <= 1'b1;
                end
            end
            case (state_q)
                IDLE: if (due_c) state_q <= EMIT;
                EMIT: begin
                    if (done_c) begin
                        if (pend_q) begin
                            pend_q <= due_c;
                            if (due_c) pend_ptr_q <= due_ptr_c;
                        end else if (!due_c) begin
                            state_q <= IDLE;
                        end
                    end else if (due_c) begin
                        if (pend_q) begin
                            overrun_q <= 1'b1;
                        end else begin
                            pend_q     <= 1'b1;
                            pend_ptr_q <= due_ptr_c;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Ring storage with a registered read port that stalls with the output.
    always_ff @(posedge clk) begin
        if (accept_c) ram_q[wr_ptr_q] <= bus.SampleAmplitudeIn;
        if (issue_c) rd_q <= ram_q[rd_addr_c];
    end

`ifdef SFFT_BARTLETT_WINDOW_EN
    localparam int unsigned PW = SAMPLE_WIDTH + LOG2_NFFT + 2;

    logic [LOG2_NFFT-1:0]           s1_t_q;
    logic                           s2_vld_q, s2_last_q;
    logic [LOG2_NFFT-1:0]           s2_idx_q;
    logic signed [SAMPLE_WIDTH-1:0] s2_data_q;
    logic [CNT_W-1:0]               t_ext_c, t_mir_c, w_min_c;
    logic signed [PW-1:0]           x_ext_c, w_ext_c, prod_c, shift_c;
    logic signed [SAMPLE_WIDTH-1:0] win_c;

    // w[t] = 2*min(t, NFFT-t); the product then shifted by LOG2_NFFT always fits the sample width.
    always_comb begin
        t_ext_c = CNT_W'(s1_t_q);
        t_mir_c = CNT_W'(NFFT) - t_ext_c;
        w_min_c = (t_ext_c < t_mir_c) ? t_ext_c : t_mir_c;
        x_ext_c = PW'(rd_q);
        w_ext_c = PW'({w_min_c, 1'b0});
        prod_c  = x_ext_c * w_ext_c;
        shift_c = prod_c >>> LOG2_NFFT;
        win_c   = SAMPLE_WIDTH'(shift_c);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_vld_q   <= 1'b0;
            s1_last_q  <= 1'b0;
            s1_idx_q   <= '0;
            out_vld_q  <= 1'b0;
            out_last_q <= 1'b0;
            out_idx_q  <= '0;
            out_data_q <= '0;
`ifdef SFFT_BARTLETT_WINDOW_EN
            s1_t_q     <= '0;
            s2_vld_q   <= 1'b0;
            s2_last_q  <= 1'b0;
            s2_idx_q   <= '0;
            s2_data_q  <= '0;
`endif
        end else if (pipe_en_c) begin
            s1_vld_q  <= issue_c;
            s1_last_q <= (issue_k_q == LOG2_NFFT'(NFFT - 1));
            s1_idx_q  <= issue_k_q;
`ifdef SFFT_BARTLETT_WINDOW_EN
            s1_t_q     <= t_c;
            s2_vld_q   <= s1_vld_q;
            s2_last_q  <= s1_last_q;
            s2_idx_q   <= s1_idx_q;
            s2_data_q  <= win_c;
            out_vld_q  <= s2_vld_q;
            out_last_q <= s2_last_q;
            out_idx_q  <= s2_idx_q;
            out_data_q <= s2_data_q;
`else
            out_vld_q  <= s1_vld_q;
            out_last_q <= s1_last_q;
            out_idx_q  <= s1_idx_q;
            out_data_q <= rd_q;
`endif
        end
    end

    assign bus.frame_valid = out_vld_q;
    assign bus.frame_data  = out_data_q;
    assign bus.frame_index = out_idx_q;
    assign bus.frame_last  = out_last_q;
    assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_sfft_frame_buffer.sv
// Bench for sfft_frame_buffer: three instances (plain, DECIM=3, BIT_REVERSE=1) share one stimulus;
// each has a reference model pushing expected frame beats into a queue popped on accepted outputs.
module tb_sfft_frame_buffer;
    localparam int SW = 24;
    localparam int N  = 32;
    localparam int L  = 5;
    localparam int H  = 8;
`ifdef SFFT_BARTLETT_WINDOW_EN
    localparam bit WIN_EN = 1'b1;
`else
    localparam bit WIN_EN = 1'b0;
`endif
    localparam int LAT = WIN_EN ? 3 : 2;

    typedef struct {
        longint d;
        int     idx;
        bit     last;
    } beat_t;

    logic                 clk;
    logic                 reset;
    logic signed [SW-1:0] samp;
    logic                 adv;
    logic                 acc;
    int                   n_chk = 0;
    int                   n_pass = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int bitrev(input int k);
        int r = 0;
        for (int b = 0; b < L; b++) r |= ((k >> b) & 1) << (L - 1 - b);
        return r;
    endfunction

    function automatic longint win(input longint x, input int t);
        longint w = 2 * ((t < N - t) ? t : N - t);
        return WIN_EN ? ((x * w) >>> L) : x;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int DEC = (g == 1) ? 3 : 1;
        localparam int BR  = (g == 2) ? 1 : 0;

        sfft_frame_buffer_if #(.SAMPLE_WIDTH(SW), .LOG2_NFFT(L)) ifc ();
        assign ifc.SampleAmplitudeIn = samp;
        assign ifc.advanceSignal     = adv;
        assign ifc.frame_accept      = acc;

        sfft_frame_buffer #(
            .SAMPLE_WIDTH(SW), .NFFT(N), .LOG2_NFFT(L), .HOP(H),
            .DECIM(DEC), .BIT_REVERSE(BR)
        ) dut (
            .clk  (clk),
            .reset(reset),
            .bus  (ifc)
        );

        beat_t  exp_q[$];
        beat_t  b;
        longint hist[2*N];
        int     wp = 0, fill = 0, hop = 0, dcnt = 0, outstanding = 0, emit_acc = 0, qn = 0;
        bit     exp_ovr = 0, stall_prev = 0, emitting, started, took;
        longint prev_d;
        int     prev_i;

        always @(negedge clk) begin
            if (reset) begin
                exp_q.delete();
                wp = 0; fill = 0; hop = 0; dcnt = 0; outstanding = 0; emit_acc = 0;
                exp_ovr = 0; stall_prev = 0; qn = 0;
            end else begin
                check_eq($sformatf("i%0d_overrun", g), longint'(ifc.overrun), longint'(exp_ovr));
                if (stall_prev) begin
                    check_eq($sformatf("i%0d_hold_valid", g), longint'(ifc.frame_valid), 1);
                    check_eq($sformatf("i%0d_hold_data", g), longint'(ifc.frame_data), prev_d);
                    check_eq($sformatf("i%0d_hold_index", g), longint'(ifc.frame_index), longint'(prev_i));
                end
                stall_prev = ifc.frame_valid && !acc;
                prev_d     = longint'(ifc.frame_data);
                prev_i     = int'(ifc.frame_index);

                emitting = (outstanding > 0);
                started  = 0;
                took     = 0;
                if (ifc.frame_valid && acc) begin
                    if (exp_q.size() == 0) begin
                        check_eq($sformatf("i%0d_spurious_valid", g), longint'(ifc.frame_valid), 0);
                    end else begin
                        b = exp_q.pop_front();
                        check_eq($sformatf("i%0d_data_k%0d", g, b.idx), longint'(ifc.frame_data), b.d);
                        check_eq($sformatf("i%0d_index", g), longint'(ifc.frame_index), longint'(b.idx));
                        check_eq($sformatf("i%0d_last_k%0d", g, b.idx), longint'(ifc.frame_last), longint'(b.last));
                        if (b.last) begin
                            outstanding--;
                            if (outstanding > 0) started = 1;
                        end
                    end
                end
                if (adv) begin
                    if (dcnt == 0) begin
                        took = 1;
                        hist[wp] = longint'(samp);
                        wp = (wp + 1) % (2 * N);
                        if (fill < N) fill++;
                        if (hop < H) hop++;
                        if (fill == N && hop == H) begin
                            hop = 0;
                            if (outstanding >= 2) begin
                                exp_ovr = 1;
                            end else begin
                                for (int k = 0; k < N; k++) begin
                                    int t;
                                    t = BR ? bitrev(k) : k;
                                    b.d    = win(hist[(wp - N + t + 2 * N) % (2 * N)], t);
                                    b.idx  = k;
                                    b.last = (k == N - 1);
                                    exp_q.push_back(b);
                                end
                                if (outstanding == 0) started = 1;
                                outstanding++;
                            end
                        end
                    end
                    dcnt = (dcnt == DEC - 1) ? 0 : dcnt + 1;
                end
                if (started) begin
                    emit_acc = 0;
                end else if (emitting && took && emit_acc < N) begin
                    emit_acc++;
                    if (emit_acc == N) exp_ovr = 1;
                end
                qn = exp_q.size();
            end
        end
    end

    task automatic push(input longint base, input longint inc, input int cnt, input int gap);
        for (int i = 0; i < cnt; i++) begin
            samp = SW'(base + longint'(i) * inc);
            adv  = 1'b1;
            @(posedge clk); #1;
            adv  = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
    endtask

    task automatic drain();
        int i = 0;
        while ((g_inst[0].qn + g_inst[1].qn + g_inst[2].qn) != 0 && i < 3000) begin
            @(posedge clk); #1;
            i++;
        end
        check_eq("drain_empty", longint'(g_inst[0].qn + g_inst[1].qn + g_inst[2].qn), 0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        adv   = 1'b0;
        acc   = 1'b1;
        samp  = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_valid", longint'(g_inst[0].ifc.frame_valid), 0);
        check_eq("rst_data", longint'(g_inst[0].ifc.frame_data), 0);
        check_eq("rst_index", longint'(g_inst[0].ifc.frame_index), 0);
        check_eq("rst_last", longint'(g_inst[0].ifc.frame_last), 0);
        check_eq("rst_overrun", longint'(g_inst[0].ifc.overrun), 0);
        reset = 1'b0;

        // first frame and its latency after the NFFT-th sample
        push(1, 1, 31, 0);
        samp = SW'(32);
        adv  = 1'b1;
        @(posedge clk); #1;
        adv  = 1'b0;
        check_eq("lat_e0", longint'(g_inst[0].ifc.frame_valid), 0);
        for (int e = 1; e <= LAT; e++) begin
            @(posedge clk); #1;
            check_eq($sformatf("lat_e%0d", e), longint'(g_inst[0].ifc.frame_valid), (e == LAT) ? 1 : 0);
        end
        drain();

        // hop: second frame 9..40
        push(33, 1, 8, 0);
        drain();
        check_eq("t2_overrun", longint'(g_inst[0].ifc.overrun), 0);

        // stall at slot 10
        push(41, 1, 8, 0);
        for (int i = 0; i < 200 && !(g_inst[0].ifc.frame_valid && g_inst[0].ifc.frame_index == 10); i++) begin
            @(posedge clk); #1;
        end
        check_eq("t3_slot10_reached", longint'(g_inst[0].ifc.frame_valid && g_inst[0].ifc.frame_index == 10), 1);
        acc = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        check_eq("t3_index_held", longint'(g_inst[0].ifc.frame_index), 10);
        acc = 1'b1;
        drain();

        // decimation (instance 1), spaced strobes
        do_reset();
        push(1, 1, 96, 4);
        drain();

        // pending then dropped frame with the sink stalled
        do_reset();
        acc = 1'b0;
        push(1, 1, 32, 0);
        push(33, 1, 8, 0);
        check_eq("t5_ovr_at_p8", longint'(g_inst[0].ifc.overrun), 0);
        push(41, 1, 7, 0);
        check_eq("t5_ovr_at_p15", longint'(g_inst[0].ifc.overrun), 0);
        push(48, 1, 1, 0);
        check_eq("t5_ovr_at_p16", longint'(g_inst[0].ifc.overrun), 1);
        acc = 1'b1;
        drain();
        check_eq("t5_ovr_sticky", longint'(g_inst[0].ifc.overrun), 1);
        do_reset();
        check_eq("t5_ovr_reset", longint'(g_inst[0].ifc.overrun), 0);

        // constant input exercises the window shape
        push(64, 0, 32, 0);
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
